// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// One request may be outstanding. rvalid returns at least one cycle after the grant.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time, holds it in a
// one-entry output register for decode, and squashes wrong-path fetches on redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               PCSrc,
    input  logic [31:0]        PCTarget,
    fetch_unit_if.master       imem,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [31:0]        Instr,
    output logic [31:0]        PC,
    output logic [31:0]        PCPlus4,
    output logic               misalign
);

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        FULL,
        DRAIN
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_q;
    logic [31:0] req_q;
    logic        grant;
    logic        resp;
    logic        accept;

    assign grant  = imem.imem_req & imem.imem_gnt;
    assign resp   = imem.imem_rvalid;
    assign accept = instr_valid & instr_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Redirect outranks every other event; rvalid only matters while a request is outstanding.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            FETCH: begin
                if (!PCSrc && imem.imem_gnt) state_next = WAIT;
            end
            WAIT: begin
                if (resp)       state_next = PCSrc ? FETCH : FULL;
                else if (PCSrc) state_next = DRAIN;
            end
            FULL: begin
                if (PCSrc || accept) state_next = FETCH;
            end
            DRAIN: begin
                if (resp) state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    // Gating the request with PCSrc keeps a wrong-path grant from ever happening.
    always_comb begin
        imem.imem_req  = reset_n && (state == FETCH) && !PCSrc;
        imem.imem_addr = pc_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q        <= RESET_PC;
            req_q       <= RESET_PC;
            instr_valid <= 1'b0;
            Instr       <= NOP_INSTR;
            PC          <= RESET_PC;
            PCPlus4     <= RESET_PC + 32'd4;
            misalign    <= 1'b0;
        end else begin
            misalign <= PCSrc & (|PCTarget[1:0]);
            if (PCSrc) begin
                pc_q        <= {PCTarget[31:2], 2'b00};
                instr_valid <= 1'b0;
                Instr       <= NOP_INSTR;
            end else begin
                if (grant) begin
                    req_q <= pc_q;
                end
                if ((state == WAIT) && resp) begin
                    Instr       <= imem.imem_rdata;
                    PC          <= req_q;
                    PCPlus4     <= req_q + 32'd4;
                    instr_valid <= 1'b1;
                    pc_q        <= req_q + 32'd4;
                end else if ((state == FULL) && accept) begin
                    instr_valid <= 1'b0;
                    Instr       <= NOP_INSTR;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a transaction-level model predicts the
// fetch stream, and a negedge monitor compares the DUT against it.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        PCSrc = 1'b0;
    logic [31:0] PCTarget = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        misalign;

    fetch_unit_if imem();

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .PCSrc      (PCSrc),
        .PCTarget   (PCTarget),
        .imem       (imem),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .Instr      (Instr),
        .PC         (PC),
        .PCPlus4    (PCPlus4),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    int   accepted    = 0;
    exp_t sb[$];

    // Reference model: next fetch address, one outstanding request, one held entry.
    logic [31:0] m_pc       = RESET_PC;
    logic [31:0] m_req_addr = RESET_PC;
    bit          m_out      = 0;
    bit          m_alive    = 0;
    bit          m_held     = 0;
    bit          m_mis      = 0;

    // Expectations for the cycle currently on the wires.
    bit          e_req  = 0;
    bit          e_held = 0;
    bit          e_mis  = 0;
    bit          e_rst  = 1;
    logic [31:0] e_addr = RESET_PC;

    // Memory responder driven by the DUT's own handshake.
    bit          mem_out  = 0;
    logic [31:0] mem_addr = '0;
    int          mem_cnt  = 0;
    int          mem_lat  = 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = RESET_PC;
        m_out   = 0;
        m_alive = 0;
        m_held  = 0;
        m_mis   = 0;
        mem_out = 0;
        sb.delete();
    endtask

    always @(negedge clk) begin
        check("imem_req", imem.imem_req, e_req);
        if (e_req) check("imem_addr", imem.imem_addr, e_addr);
        check("misalign", misalign, e_mis);
        check("instr_valid", instr_valid, e_held);
        if (e_rst) begin
            check("reset_PC", PC, RESET_PC);
            check("reset_PCPlus4", PCPlus4, RESET_PC + 32'd4);
        end
        if (instr_valid) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_empty: instr_valid=1 with PC %h, expected no instruction", PC);
            end else begin
                check("Instr", Instr, sb[0].instr);
                check("PC", PC, sb[0].pc);
                check("PCPlus4", PCPlus4, sb[0].pc + 32'd4);
                if (PCSrc || instr_ready) begin
                    void'(sb.pop_front());
                    if (!PCSrc) accepted++;
                end
            end
        end else begin
            check("Instr_nop", Instr, NOP);
        end
    end

    task automatic step(input bit rst, input bit src, input logic [31:0] tgt,
                        input bit gnt, input bit rdy, input bit force_rv);
        bit rv;
        @(posedge clk);
        #1;
        reset_n = !rst;
        if (rst) model_reset();
        e_rst  = rst;
        e_req  = !rst && !src && !m_out && !m_held;
        e_addr = m_pc;
        e_held = m_held;
        e_mis  = m_mis;
        rv = force_rv || (mem_out && mem_cnt == 0);
        PCSrc            = src;
        PCTarget         = tgt;
        instr_ready      = rdy;
        imem.imem_gnt    = gnt;
        imem.imem_rvalid = rv;
        imem.imem_rdata  = rv ? mem_word(mem_addr) : $urandom();
        @(negedge clk);
        #1;
        if (!rst) begin
            if (mem_out && rv) mem_out = 0;
            else if (mem_out)  mem_cnt--;
            if (imem.imem_req && gnt) begin
                mem_out  = 1;
                mem_addr = imem.imem_addr;
                mem_cnt  = mem_lat - 1;
            end
            if (src) begin
                m_pc  = {tgt[31:2], 2'b00};
                m_mis = |tgt[1:0];
                if (m_out) begin
                    if (rv) m_out = 0;
                    else    m_alive = 0;
                end
                m_held = 0;
            end else begin
                m_mis = 0;
                if (e_req && gnt) begin
                    m_out      = 1;
                    m_alive    = 1;
                    m_req_addr = m_pc;
                end else if (m_out && rv) begin
                    m_out = 0;
                    if (m_alive) begin
                        sb.push_back('{pc: m_req_addr, instr: mem_word(m_req_addr)});
                        m_held = 1;
                        m_pc   = m_req_addr + 32'd4;
                    end
                end else if (m_held && rdy) begin
                    m_held = 0;
                end
            end
        end
    endtask

    initial begin
        int a0;
        imem.imem_gnt    = 1'b0;
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = '0;
        #1 reset_n = 1'b0;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1, 0);

        // Straight-line fetch with 1-cycle memory: one instruction every 3 cycles.
        mem_lat = 1;
        a0 = accepted;
        for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 1, 0);
        check("throughput_accepts", accepted - a0, 3);

        // Decode stall while full.
        for (int i = 0; i < 10 && !m_held; i++) step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 0);

        // Redirect while waiting for a slow response.
        mem_lat = 3;
        for (int i = 0; i < 10 && !m_out; i++) step(0, 0, 0, 1, 1, 0);
        step(0, 1, 32'h0000_0100, 1, 1, 0);
        mem_lat = 1;
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, 0);

        // Misaligned redirect while full.
        for (int i = 0; i < 10 && !m_held; i++) step(0, 0, 0, 1, 0, 0);
        step(0, 1, 32'h0000_0202, 1, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 0);

        // Address wrap at the top of memory.
        step(0, 1, 32'hFFFF_FFFC, 1, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1, 0);

        // Reset while a request is outstanding, then a stale rvalid.
        mem_lat = 3;
        for (int i = 0; i < 10 && !m_out; i++) step(0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);

        // Randomized traffic: redirects, stalls, variable latency, rare resets.
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] tgt;
            mem_lat = $urandom_range(1, 3);
            tgt = ($urandom_range(0, 3) == 0) ? 32'($urandom()) : 32'($urandom_range(0, 1023));
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 11) == 0,
                 tgt,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) < 7,
                 0);
        end
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
